// File: rtl/alu_seq_nibble.sv
// ---------------------------------------------------------------------------
// alu_seq_nibble -- multi-cycle WIDTH-bit ALU built around a single 4-bit
// carry-lookahead slice (cla_4). One nibble is processed per clock, LSB first.
// The slice exports group P/G but no carry out, so the nibble-to-nibble
// carry is formed here as G | (P & Cin).
//
// Ports (alu_seq_nibble):
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      operation request, accepted only when idle
//   op         in   3      000 AND, 001 OR, 010 ADD, 100 XOR, 101 NOR,
//                          110 SUB, 111 SLT, 011 reserved (result 0)
//   a, b       in   WIDTH  operands, sampled on the accepted-start edge
//   busy       out  1      high while nibbles are being processed
//   done       out  1      one-cycle pulse, result and flags valid
//   result     out  WIDTH  result register
//   carry_out  out  1      final carry (SUB/SLT: 1 = no borrow)
//   overflow   out  1      signed overflow for ADD/SUB/SLT
//   zero       out  1      final result == 0
//
// Ports (cla_4):
//   i_a, i_b, i_cin         nibble operands and carry in
//   o_sum                   4-bit sum
//   o_and/o_or/o_xor/o_nor  bitwise results
//   o_p, o_g                group propagate / generate
// ---------------------------------------------------------------------------

module cla_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic [3:0] o_and,
  output logic [3:0] o_or,
  output logic [3:0] o_xor,
  output logic [3:0] o_nor,
  output logic       o_p,
  output logic       o_g
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign w_p[gi]   = i_a[gi] ^ i_b[gi];
    assign w_g[gi]   = i_a[gi] & i_b[gi];
    assign o_sum[gi] = w_p[gi] ^ w_c[gi];
    assign o_and[gi] = i_a[gi] & i_b[gi];
    assign o_or[gi]  = i_a[gi] | i_b[gi];
    assign o_xor[gi] = i_a[gi] ^ i_b[gi];
    assign o_nor[gi] = ~(i_a[gi] | i_b[gi]);
  end

  // Internal carries flattened (lookahead) rather than rippled.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_p = &w_p;
  assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module alu_seq_nibble #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [NW-1:0]    r_nib;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_sub;
  logic             w_arith;
  logic             w_last;
  logic [WIDTH-1:0] w_b_eff;
  logic [NW+1:0]    w_bit_idx;
  logic [3:0]       w_sl_a;
  logic [3:0]       w_sl_b;
  logic [3:0]       w_sum;
  logic [3:0]       w_and;
  logic [3:0]       w_or;
  logic [3:0]       w_xor;
  logic [3:0]       w_nor;
  logic             w_p;
  logic             w_g;
  logic             w_cout;
  logic [3:0]       w_nib_res;
  logic [WIDTH-1:0] w_result_upd;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final_result;

  assign w_sub     = (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_arith   = w_sub || (r_op == OP_ADD);
  assign w_last    = (r_nib == NW'(NIBBLES - 1));
  assign w_b_eff   = w_sub ? ~r_b : r_b;
  assign w_bit_idx = {r_nib, 2'b00};
  assign w_sl_a    = r_a[w_bit_idx +: 4];
  assign w_sl_b    = w_b_eff[w_bit_idx +: 4];

  cla_4 u_slice (
    .i_a   (w_sl_a),
    .i_b   (w_sl_b),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_and (w_and),
    .o_or  (w_or),
    .o_xor (w_xor),
    .o_nor (w_nor),
    .o_p   (w_p),
    .o_g   (w_g)
  );

  assign w_cout = w_g | (w_p & r_carry);

  always_comb begin
    w_nib_res = 4'h0;
    case (r_op)
      OP_ADD, OP_SUB, OP_SLT: w_nib_res = w_sum;
      OP_AND:                 w_nib_res = w_and;
      OP_OR:                  w_nib_res = w_or;
      OP_XOR:                 w_nib_res = w_xor;
      OP_NOR:                 w_nib_res = w_nor;
      default:                w_nib_res = 4'h0;
    endcase
  end

  always_comb begin
    w_result_upd = r_result;
    w_result_upd[w_bit_idx +: 4] = w_nib_res;
  end

  // On the last nibble w_sum[3] is the sum MSB; overflow, the SLT fixup and
  // zero are resolved on that edge so they are already valid in the done cycle.
  assign w_ovf = w_arith & (r_a[WIDTH-1] == w_b_eff[WIDTH-1])
                         & (w_sum[3] != r_a[WIDTH-1]);
  assign w_final_result = (r_op == OP_SLT)
                        ? {{(WIDTH-1){1'b0}}, w_sum[3] ^ w_ovf}
                        : w_result_upd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_nib   <= '0;
            r_carry <= (op == OP_SUB) || (op == OP_SLT);
          end
        end
        S_RUN: begin
          r_carry <= w_cout;
          r_nib   <= r_nib + 1'b1;
          if (w_last) begin
            r_result    <= w_final_result;
            r_carry_out <= w_arith & w_cout;
            r_overflow  <= w_ovf;
            r_zero      <= (w_final_result == '0);
          end else begin
            r_result <= w_result_upd;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
endmodule
